// File: rtl/adder_i4_o3_err_monitor.sv
// Error-characterisation harness for a 2-bit approximate adder: sweeps all 16
// input vectors and accumulates max/total/count error statistics against the exact sum.
module adder_i4_o3_err_monitor #(
  parameter int unsigned ET = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] dut_in,
  input  logic [2:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] max_err,
  output logic [4:0] err_count,
  output logic [6:0] sum_abs_err,
  output logic [3:0] worst_vec
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // |approx - exact| for vector v, where A = v[1:0] and B = v[3:2]
  function automatic logic [2:0] abs_err(input logic [3:0] v, input logic [2:0] approx);
    logic [2:0] exact;
    logic [3:0] diff;
    exact   = {1'b0, v[1:0]} + {1'b0, v[3:2]};
    diff    = {1'b0, approx} - {1'b0, exact};
    abs_err = diff[3] ? 3'(4'd0 - diff) : diff[2:0];
  endfunction

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] dut_in_q, dut_in_d;
  logic       eval_vld_q, eval_vld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] max_err_q, max_err_d;
  logic [4:0] err_count_q, err_count_d;
  logic [6:0] sum_abs_err_q, sum_abs_err_d;
  logic [3:0] worst_vec_q, worst_vec_d;
  logic [2:0] err_s;

  // The vector on dut_in_q has had a full cycle to settle through the adder.
  assign err_s = abs_err(dut_in_q, dut_out);

  // Next-state and statistics update
  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    dut_in_d      = dut_in_q;
    eval_vld_d    = eval_vld_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    max_err_d     = max_err_q;
    err_count_d   = err_count_q;
    sum_abs_err_d = sum_abs_err_q;
    worst_vec_d   = worst_vec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        dut_in_d = 4'd0;
        if (start) begin
          state_d       = S_SWEEP;
          vec_d         = 4'd0;
          eval_vld_d    = 1'b1;
          busy_d        = 1'b1;
          max_err_d     = 3'd0;
          err_count_d   = 5'd0;
          sum_abs_err_d = 7'd0;
          worst_vec_d   = 4'd0;
        end else begin
          state_d    = S_IDLE;
          eval_vld_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      S_SWEEP: begin
        if (eval_vld_q) begin
          err_count_d   = err_count_q + {4'd0, (err_s != 3'd0)};
          sum_abs_err_d = sum_abs_err_q + {4'd0, err_s};
          // Strictly greater, so ties keep the earlier vector
          if (err_s > max_err_q) begin
            max_err_d   = err_s;
            worst_vec_d = dut_in_q;
          end else begin
            max_err_d   = max_err_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        if (vec_q == 4'd15) begin
          state_d    = S_DONE;
          dut_in_d   = 4'd0;
          eval_vld_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          vec_d    = vec_q + 4'd1;
          dut_in_d = vec_q + 4'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        vec_d      = 4'd0;
        dut_in_d   = 4'd0;
        eval_vld_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vec_q         <= 4'd0;
      dut_in_q      <= 4'd0;
      eval_vld_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      max_err_q     <= 3'd0;
      err_count_q   <= 5'd0;
      sum_abs_err_q <= 7'd0;
      worst_vec_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      dut_in_q      <= dut_in_d;
      eval_vld_q    <= eval_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      max_err_q     <= max_err_d;
      err_count_q   <= err_count_d;
      sum_abs_err_q <= sum_abs_err_d;
      worst_vec_q   <= worst_vec_d;
    end
  end

  assign dut_in      = dut_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign max_err     = max_err_q;
  assign err_count   = err_count_q;
  assign sum_abs_err = sum_abs_err_q;
  assign worst_vec   = worst_vec_q;
  assign pass        = ({29'd0, max_err_q} <= ET);

endmodule

// File: tb/tb_adder_i4_o3_err_monitor.sv
// Scoreboard bench: two monitors (ET=1, ET=0) each wrapped around a behavioural adder model.
module tb_adder_i4_o3_err_monitor;

  typedef struct {
    int mx;
    int cnt;
    int sum;
    int worst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;
  logic [3:0] dut_in_a, dut_in_b;
  logic [2:0] dut_out_a, dut_out_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] max_err_a, max_err_b;
  logic [4:0] err_count_a, err_count_b;
  logic [6:0] sum_abs_err_a, sum_abs_err_b;
  logic [3:0] worst_vec_a, worst_vec_b;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb_q[$];

  always #5 clk = ~clk;

  // Adder models: 0 exact, 1 stuck-at-0, 2 A+B+1, 3 constant 7
  function automatic logic [2:0] adder_model(input int m, input logic [3:0] v);
    logic [2:0] s;
    s = {1'b0, v[1:0]} + {1'b0, v[3:2]};
    case (m)
      0:       adder_model = s;
      1:       adder_model = 3'd0;
      2:       adder_model = s + 3'd1;
      default: adder_model = 3'd7;
    endcase
  endfunction

  assign dut_out_a = adder_model(mode, dut_in_a);
  assign dut_out_b = adder_model(mode, dut_in_b);

  adder_i4_o3_err_monitor #(.ET(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .max_err(max_err_a),
    .err_count(err_count_a), .sum_abs_err(sum_abs_err_a), .worst_vec(worst_vec_a)
  );

  adder_i4_o3_err_monitor #(.ET(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .max_err(max_err_b),
    .err_count(err_count_b), .sum_abs_err(sum_abs_err_b), .worst_vec(worst_vec_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, ".dut_in"}, int'(dut_in_a), 0);
    check_eq({tag, ".busy"}, int'(busy_a), 0);
    check_eq({tag, ".done"}, int'(done_a), 0);
    check_eq({tag, ".max_err"}, int'(max_err_a), 0);
    check_eq({tag, ".err_count"}, int'(err_count_a), 0);
    check_eq({tag, ".sum"}, int'(sum_abs_err_a), 0);
    check_eq({tag, ".worst"}, int'(worst_vec_a), 0);
    check_eq({tag, ".pass_a"}, int'(pass_a), 1);
    check_eq({tag, ".pass_b"}, int'(pass_b), 1);
  endtask

  // Reference statistics computed with plain integers from the operand definition
  task automatic push_expected(input int m);
    exp_t e;
    int exact, approx, d;
    e = '{mx: 0, cnt: 0, sum: 0, worst: 0};
    for (int v = 0; v < 16; v++) begin
      exact = (v % 4) + (v / 4);
      if (m == 0) approx = exact;
      else if (m == 1) approx = 0;
      else if (m == 2) approx = exact + 1;
      else approx = 7;
      d = (approx > exact) ? approx - exact : exact - approx;
      if (d != 0) e.cnt++;
      e.sum += d;
      if (d > e.mx) begin
        e.mx = d;
        e.worst = v;
      end
    end
    sb_q.push_back(e);
  endtask

  // One sweep; poke > 0 re-asserts start at that sweep cycle
  task automatic run_sweep(input int m, input int poke, input string tag);
    int cyc;
    bit got;
    exp_t e;
    mode = m;
    push_expected(m);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, ".busy0"}, int'(busy_a), 1);
    check_eq({tag, ".dut_in0"}, int'(dut_in_a), 0);
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (done_a) got = 1'b1;
      else if (m == 3 && cyc <= 15) check_eq($sformatf("%s.dut_in%0d", tag, cyc), int'(dut_in_a), cyc);
      if (cyc == poke) start = 1'b1;
    end
    check_eq({tag, ".latency"}, cyc, 16);
    if (got) begin
      e = sb_q.pop_front();
      check_eq({tag, ".busy_at_done"}, int'(busy_a), 0);
      check_eq({tag, ".max_err"}, int'(max_err_a), e.mx);
      check_eq({tag, ".err_count"}, int'(err_count_a), e.cnt);
      check_eq({tag, ".sum"}, int'(sum_abs_err_a), e.sum);
      check_eq({tag, ".worst"}, int'(worst_vec_a), e.worst);
      check_eq({tag, ".pass_et1"}, int'(pass_a), (e.mx <= 1) ? 1 : 0);
      check_eq({tag, ".pass_et0"}, int'(pass_b), (e.mx == 0) ? 1 : 0);
      check_eq({tag, ".max_err_b"}, int'(max_err_b), e.mx);
      @(posedge clk);
      #1;
      check_eq({tag, ".done_pulse"}, int'(done_a), 0);
      check_eq({tag, ".hold_sum"}, int'(sum_abs_err_a), e.sum);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_reset("idle");

    run_sweep(0, 0, "exact");
    run_sweep(1, 0, "stuck0");
    run_sweep(2, 0, "plus1");
    run_sweep(3, 0, "const7");
    run_sweep(1, 5, "restart_ignored");

    // Reset in the middle of a sweep
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("midrst.busy_before", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check_idle_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (done_a || busy_a) seen++;
      end
      check_eq("midrst.no_done", seen, 0);
    end
    run_sweep(2, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
